xoodoo_sponge_ctrl: RTL and testbench

//  Sponge absorb/squeeze controller that sits directly upstream of the 12-round Xoodoo permutation core.
//  - Accepts a 32-bit message word stream (valid/ready) and XORs each word into the rate part of a held
//    384-bit state.
//  - Pads and domain-separates the final block, then launches the permutation per rate block.
//  - Streams the digest words (valid/ready) from the rate part after each permutation.
//  - Owns the only copy of the sponge state; the permutation core is a stateless-between-runs slave.

---
 rtl/xoodoo_sponge_ctrl.sv | 151 +++++++++++++++
 tb/tb_xoodoo_sponge_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoodoo_sponge_ctrl.sv
// Xoodoo sponge controller: absorbs a 32-bit word stream into a 384-bit state,
// pads/domain-separates, drives the permutation core and squeezes the digest.
module xoodoo_sponge_ctrl #(
  parameter int          RATE_WORDS    = 4,
  parameter int          DIGEST_BLOCKS = 2,
  parameter logic [31:0] PAD_WORD      = 32'h0000_0001,
  parameter logic [31:0] DOMAIN        = 32'h0100_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_start,
  input  logic         cmd_empty,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         perm_start,
  output logic [383:0] perm_state,
  input  logic         perm_done,
  input  logic [383:0] perm_result
);

  localparam int BW = (DIGEST_BLOCKS > 1) ? $clog2(DIGEST_BLOCKS) : 1;
  localparam logic [3:0]    WLAST = 4'(RATE_WORDS - 1);
  localparam logic [BW-1:0] BLAST = BW'(DIGEST_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE, ABSORB, PAD, PERM_A, SQUEEZE, PERM_S, DONE
  } fsm_t;

  fsm_t        fsm;
  logic [31:0] st [12];
  logic [3:0]  widx;
  logic [BW-1:0] bcnt;
  logic        fin;
  logic        pend;

  // word value bit 31 sits at the lowest state index of its slot
  function automatic logic [31:0] rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always_comb begin
    perm_state = '0;
    for (int k = 0; k < 12; k++)
      perm_state[32*k +: 32] = rev(st[k]);
  end

  assign busy      = (fsm != IDLE);
  assign in_ready  = (fsm == ABSORB);
  assign out_valid = (fsm == SQUEEZE);
  assign out_data  = (fsm == SQUEEZE) ? st[widx] : '0;
  assign out_last  = (fsm == SQUEEZE) && (widx == WLAST)
                   && (bcnt == BLAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm        <= IDLE;
      widx       <= '0;
      bcnt       <= '0;
      fin        <= 1'b0;
      pend       <= 1'b0;
      perm_start <= 1'b0;
      for (int k = 0; k < 12; k++) st[k] <= '0;
    end else begin
      perm_start <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (cmd_start) begin
            for (int k = 0; k < 12; k++) st[k] <= '0;
            widx <= '0;
            bcnt <= '0;
            fin  <= 1'b0;
            pend <= 1'b0;
            fsm  <= cmd_empty ? PAD : ABSORB;
          end
        end
        ABSORB: begin
          if (in_valid) begin
            st[widx] <= st[widx] ^ in_data;
            if (widx == WLAST) begin
              // full block: a last word here defers the pad to a fresh block
              widx       <= '0;
              fin        <= 1'b0;
              pend       <= in_last;
              perm_start <= 1'b1;
              fsm        <= PERM_A;
            end else begin
              widx <= widx + 4'd1;
              if (in_last) fsm <= PAD;
            end
          end
        end
        PAD: begin
          for (int k = 0; k < 12; k++)
            st[k] <= st[k]
                   ^ ((4'(k) == widx) ? PAD_WORD : 32'h0)
                   ^ ((k == 11) ? DOMAIN : 32'h0);
          fin        <= 1'b1;
          pend       <= 1'b0;
          perm_start <= 1'b1;
          fsm        <= PERM_A;
        end
        PERM_A: begin
          if (perm_done) begin
            for (int k = 0; k < 12; k++)
              st[k] <= rev(perm_result[32*k +: 32]);
            widx <= '0;
            if (fin)       fsm <= SQUEEZE;
            else if (pend) fsm <= PAD;
            else           fsm <= ABSORB;
          end
        end
        SQUEEZE: begin
          if (out_ready) begin
            if (widx == WLAST) begin
              widx <= '0;
              if (bcnt != BLAST) begin
                bcnt       <= bcnt + 1'b1;
                perm_start <= 1'b1;
                fsm        <= PERM_S;
              end else begin
                fsm <= DONE;
              end
            end else begin
              widx <= widx + 4'd1;
            end
          end
        end
        PERM_S: begin
          if (perm_done) begin
            for (int k = 0; k < 12; k++)
              st[k] <= rev(perm_result[32*k +: 32]);
            widx <= '0;
            fsm  <= SQUEEZE;
          end
        end
        DONE:    fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_sponge_ctrl.sv
// Scoreboard bench for xoodoo_sponge_ctrl with a stub permutation
// that returns the inverted state three cycles after perm_start.
module tb_xoodoo_sponge_ctrl;

  localparam logic [31:0] PADW = 32'h0000_0001;
  localparam logic [31:0] DOM  = 32'h0100_0000;

  typedef logic [31:0] wa_t [12];

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         cmd_start = 1'b0;
  logic         cmd_empty = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         perm_start;
  logic [383:0] perm_state;
  logic         perm_done = 1'b0;
  logic [383:0] perm_result = '0;

  int vecs = 0;
  int miss = 0;

  logic [383:0] eperm [$];
  logic [32:0]  eout  [$];

  xoodoo_sponge_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cmd_start(cmd_start), .cmd_empty(cmd_empty),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .perm_start(perm_start),
    .perm_state(perm_state), .perm_done(perm_done),
    .perm_result(perm_result)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] pk(input wa_t w);
    logic [383:0] v;
    v = '0;
    for (int k = 0; k < 12; k++)
      for (int i = 0; i < 32; i++)
        v[32*k + i] = w[k][31-i];
    return v;
  endfunction

  // stub permutation core
  initial begin
    logic [383:0] snap;
    forever begin
      @(negedge clk);
      if (resetn && perm_start) begin
        snap = perm_state;
        repeat (3) @(posedge clk);
        #1;
        perm_result = ~snap;
        perm_done   = 1'b1;
        @(posedge clk);
        #1;
        perm_done = 1'b0;
      end
    end
  end

  // monitor
  initial begin
    logic [383:0] ep;
    logic [32:0]  eo;
    forever begin
      @(negedge clk);
      if (resetn && perm_start) begin
        vecs++;
        if (eperm.size() == 0) begin
          miss++;
          $display("FAIL perm_start: unexpected launch, state=%h", perm_state);
        end else begin
          ep = eperm.pop_front();
          if (perm_state !== ep) begin
            miss++;
            $display("FAIL perm_state: got %h want %h", perm_state, ep);
          end
        end
      end
      if (resetn && out_valid && out_ready) begin
        vecs++;
        if (eout.size() == 0) begin
          miss++;
          $display("FAIL digest: unexpected word %h", out_data);
        end else begin
          eo = eout.pop_front();
          if ({out_last, out_data} !== eo) begin
            miss++;
            $display("FAIL digest: got last=%b data=%h want last=%b data=%h",
                     out_last, out_data, eo[32], eo[31:0]);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [511:0] got,
                       input logic [511:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // expectations from the final absorb state through the two squeeze blocks
  task automatic expect_sq(input wa_t s);
    eperm.push_back(pk(s));
    for (int k = 0; k < 4; k++) eout.push_back({1'b0, ~s[k]});
    eperm.push_back(~pk(s));
    for (int k = 0; k < 4; k++) eout.push_back({k == 3, s[k]});
  endtask

  task automatic start(input logic e);
    @(posedge clk); #1;
    cmd_start = 1'b1;
    cmd_empty = e;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cmd_empty = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("in_ready timeout", 512'(ok), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_msg(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check({nm, " idle timeout"}, 512'(ok), 512'(1));
    check({nm, " queues drained"},
          512'(eperm.size() + eout.size()), 512'(0));
  endtask

  initial begin
    wa_t s;
    wa_t a;
    bit  ok;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset outputs",
          {perm_state, busy, in_ready, out_valid, out_last, perm_start, out_data},
          '0);

    // empty message
    s = '{default: 32'h0};
    s[0] = PADW; s[11] = DOM;
    expect_sq(s);
    start(1'b1);
    finish_msg("empty");

    // single word, plus a dropped cmd_start while busy
    s = '{default: 32'h0};
    s[0] = 32'hDEAD_BEEF; s[1] = PADW; s[11] = DOM;
    expect_sq(s);
    start(1'b0);
    send(32'hDEAD_BEEF, 1'b1);
    start(1'b1);
    finish_msg("one word");

    // block exactly full at in_last
    a = '{default: 32'h0};
    a[0] = 32'h0123_4567; a[1] = 32'h89AB_CDEF;
    a[2] = 32'h0F0F_0F0F; a[3] = 32'hA5A5_5A5A;
    eperm.push_back(pk(a));
    for (int k = 0; k < 12; k++) s[k] = ~a[k];
    s[0]  = s[0] ^ PADW;
    s[11] = s[11] ^ DOM;
    expect_sq(s);
    start(1'b0);
    for (int k = 0; k < 4; k++) send(a[k], k == 3);
    finish_msg("full block");

    // two words, full digest
    s = '{default: 32'h0};
    s[0] = 32'h1111_1111; s[1] = 32'h2222_2222; s[2] = PADW; s[11] = DOM;
    expect_sq(s);
    start(1'b0);
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b1);
    finish_msg("two words");

    // sink stalls mid-squeeze
    s = '{default: 32'h0};
    s[0] = 32'hCAFE_0001; s[1] = 32'hCAFE_0002;
    s[2] = 32'hCAFE_0003; s[3] = PADW; s[11] = DOM;
    expect_sq(s);
    @(posedge clk); #1 out_ready = 1'b0;
    start(1'b0);
    send(32'hCAFE_0001, 1'b0);
    send(32'hCAFE_0002, 1'b0);
    send(32'hCAFE_0003, 1'b1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    check("squeeze timeout", 512'(ok), 512'(1));
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall hold",
            {out_valid, out_data, perm_start},
            {1'b1, ~s[2], 1'b0});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    finish_msg("stall");

    // reset during PERM_A with perm_done arriving inside reset
    s = '{default: 32'h0};
    s[0] = 32'h5555_AAAA; s[1] = PADW; s[11] = DOM;
    eperm.push_back(pk(s));
    start(1'b0);
    send(32'h5555_AAAA, 1'b1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (perm_start) begin ok = 1; break; end
    end
    check("perm_start timeout", 512'(ok), 512'(1));
    @(posedge clk); #1 resetn = 1'b0;
    repeat (6) @(negedge clk);
    check("in reset outputs",
          {perm_state, busy, in_ready, out_valid, out_last, perm_start, out_data},
          '0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("post reset outputs",
          {perm_state, busy, in_ready, out_valid, out_last, perm_start, out_data},
          '0);
    check("post reset queues", 512'(eperm.size() + eout.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
